fdivsqrt_sequencer: RTL

- Control FSM that sequences the iterative divide/square-root datapath.
- Accepts an operation request in Execute together with a precomputed iteration count (CyclesE). Drives the per-cycle iteration enable and holds the pipeline busy while iterating.
- Signals completion to Memory, handles special-case bypass, flush and downstream stall.
- Sits between the FPU/IEU issue logic and the divsqrt iteration datapath.

---
 rtl/fdivsqrt_sequencer_if.sv | 28 ++
 rtl/fdivsqrt_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fdivsqrt_sequencer_if.sv
// Handshake bundle between the FPU/IEU issue logic and the divsqrt sequencer.
// The issue side holds the master modport; the sequencer holds the slave modport.
interface fdivsqrt_sequencer_if #(
    parameter int unsigned DURLEN = 6
);
    logic              StartE;
    logic [DURLEN-1:0] CyclesE;
    logic              SpecialCaseE;
    logic              WZeroE;
    logic              FlushE;
    logic              StallM;
    logic              IterEnE;
    logic              InitE;
    logic              BusyE;
    logic              DoneM;
    logic              SpecialM;
    logic [DURLEN-1:0] StepCnt;

    modport master (
        output StartE, CyclesE, SpecialCaseE, WZeroE, FlushE, StallM,
        input  IterEnE, InitE, BusyE, DoneM, SpecialM, StepCnt
    );

    modport slave (
        input  StartE, CyclesE, SpecialCaseE, WZeroE, FlushE, StallM,
        output IterEnE, InitE, BusyE, DoneM, SpecialM, StepCnt
    );
endinterface

// File: rtl/fdivsqrt_sequencer.sv
// Control FSM for the iterative divide/square-root datapath.
// IDLE accepts a request, BUSY runs max(CyclesE, MINCYC) iteration cycles,
// DONE presents the result to Memory and holds it while StallM is high.
// Optional build macro FDIVSQRT_EARLYTERM_EN: a zero partial remainder
// (WZeroE) during iteration finishes the operation early.
module fdivsqrt_sequencer #(
    parameter int unsigned DURLEN = 6,
    parameter int unsigned MINCYC = 1
) (
    input logic                  clk,
    input logic                  reset_n,
    fdivsqrt_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DURLEN-1:0] MIN_CNT = DURLEN'(MINCYC);

    state_t            state;
    logic [DURLEN-1:0] step_cnt;
    logic              done_q;
    logic              special_q;
    logic              start_ok;
    logic              early_term;
    logic [DURLEN-1:0] load_cnt;

    assign start_ok = bus.StartE & ~bus.FlushE;

`ifdef FDIVSQRT_EARLYTERM_EN
    assign early_term = bus.WZeroE;
`else
    assign early_term = bus.WZeroE & 1'b0;
`endif

    // Iteration count for a new operation, clamped up to the minimum
    always_comb begin
        load_cnt = bus.CyclesE;
        if (bus.CyclesE < MIN_CNT) begin
            load_cnt = MIN_CNT;
        end
    end

    // Sequencer state, step counter and registered completion flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            step_cnt  <= '0;
            done_q    <= 1'b0;
            special_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        if (bus.SpecialCaseE) begin
                            state     <= DONE;
                            step_cnt  <= '0;
                            done_q    <= 1'b1;
                            special_q <= 1'b1;
                        end else begin
                            state     <= BUSY;
                            step_cnt  <= load_cnt;
                            done_q    <= 1'b0;
                            special_q <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.FlushE) begin
                        state     <= IDLE;
                        step_cnt  <= '0;
                        done_q    <= 1'b0;
                        special_q <= 1'b0;
                    end else if ((step_cnt <= DURLEN'(1)) || early_term) begin
                        // A count of zero also completes, so the counter never wraps
                        state    <= DONE;
                        step_cnt <= '0;
                        done_q   <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt - DURLEN'(1);
                    end
                end
                DONE: begin
                    if (bus.FlushE || !bus.StallM) begin
                        state     <= IDLE;
                        step_cnt  <= '0;
                        done_q    <= 1'b0;
                        special_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    step_cnt  <= '0;
                    done_q    <= 1'b0;
                    special_q <= 1'b0;
                end
            endcase
        end
    end

    // Same-cycle controls: issue stall, operand load and iteration enable
    always_comb begin
        bus.IterEnE = 1'b0;
        bus.InitE   = 1'b0;
        bus.BusyE   = 1'b0;
        case (state)
            IDLE: begin
                bus.InitE = start_ok;
                bus.BusyE = start_ok & ~bus.SpecialCaseE;
            end
            BUSY: begin
                bus.IterEnE = ~bus.FlushE;
                bus.BusyE   = 1'b1;
            end
            DONE: begin
                bus.BusyE = bus.StallM;
            end
            default: begin
                bus.BusyE = 1'b0;
            end
        endcase
        // Keep the request-driven IDLE outputs quiet while reset is held
        if (!reset_n) begin
            bus.IterEnE = 1'b0;
            bus.InitE   = 1'b0;
            bus.BusyE   = 1'b0;
        end
    end

    assign bus.DoneM    = done_q;
    assign bus.SpecialM = special_q;
    assign bus.StepCnt  = step_cnt;
endmodule
